// File: rtl/avalon_slave_pkg.sv
// rtl/avalon_slave_pkg.sv - shared constants, types and helpers for the Avalon-MM slave memory
package avalon_slave_pkg;

  localparam int WAITSTATES_MIN  = 0;
  localparam int WAITSTATES_MAX  = 15;
  localparam int READLATENCY_MIN = 1;
  localparam int READLATENCY_MAX = 8;

  localparam int DEF_NBDATABYTES = 2;

  typedef logic [3:0]                   wcnt_t;
  typedef logic [7:0]                   byte_t;
  typedef logic [8*DEF_NBDATABYTES-1:0] word_t;
  typedef logic [DEF_NBDATABYTES-1:0]   be_t;

  function automatic int calc_dw(input int nbytes);
    return 8 * nbytes;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// rtl/avalon_rd_pipe.sv - fixed-latency read return shift register with synchronous flush
module avalon_rd_pipe
  import avalon_slave_pkg::*;
#(
  parameter int DW      = 16,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [DW-1:0]      dat [LATENCY];

  // Data stages load only behind a valid, so the last stage holds between returns.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/avalon_slave_mem.sv
// rtl/avalon_slave_mem.sv - Avalon-MM slave register-array memory, variable wait, pipelined reads
module avalon_slave_mem
  import avalon_slave_pkg::*;
#(
  parameter  int NBDATABYTES = 2,
  parameter  int NBADDRBITS  = 8,
  parameter  int WAITSTATES  = 2,
  parameter  int READLATENCY = 1,
  localparam int DW          = calc_dw(NBDATABYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBADDRBITS-1:0]  address,
  input  logic [NBDATABYTES-1:0] byteenable,
  input  logic [DW-1:0]          writedata,
  input  logic                   read,
  input  logic                   write,
  output logic [DW-1:0]          readdata,
  output logic                   waitrequest,
  output logic                   readdatavalid,
  output logic                   protocol_error
);

  localparam int    DEPTH = 1 << NBADDRBITS;
  localparam wcnt_t WS    = wcnt_t'(clamp(WAITSTATES, WAITSTATES_MIN, WAITSTATES_MAX));
  localparam int    RL    = clamp(READLATENCY, READLATENCY_MIN, READLATENCY_MAX);

  logic [DW-1:0] mem [DEPTH];
  wcnt_t         wcnt;
  logic          req;
  logic          accept;
  logic          rd_accept;
  logic          wr_accept;
  logic          pipe_valid;

  assign req         = read | write;
  assign waitrequest = req & (wcnt < WS);
  assign accept      = req & ~waitrequest & ~rst;
  assign rd_accept   = accept & read;
  // A simultaneous read+write is treated as a read only.
  assign wr_accept   = accept & write & ~read;

  always_ff @(posedge clk) begin
    if (rst || !req || accept) wcnt <= '0;
    else                       wcnt <= wcnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_accept) begin
      for (int b = 0; b < NBDATABYTES; b++)
        if (byteenable[b]) mem[address][8*b +: 8] <= byte_t'(writedata[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                protocol_error <= 1'b0;
    else if (read && write) protocol_error <= 1'b1;
  end

  avalon_rd_pipe #(
    .DW      (DW),
    .LATENCY (RL)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_accept),
    .in_data   (mem[address]),
    .out_valid (pipe_valid),
    .out_data  (readdata)
  );

  // A return landing in a reset cycle is killed here; the flush clears the rest.
  assign readdatavalid = pipe_valid & ~rst;

endmodule
